// File: rtl/ps2_host_tx_if.sv
// Request/status bundle between a command source and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, tx_err, err_code, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, tx_err, err_code, busy
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clock/data pins.
// Define PS2_TX_ACK_CHECK_EN to report a missing device ack as tx_err (code 2).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          board_clk,
    input  logic          reset,
    ps2_host_tx_if.slave  host,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam logic [5:0] S_IDLE    = 6'b000001;
    localparam logic [5:0] S_INHIBIT = 6'b000010;
    localparam logic [5:0] S_START   = 6'b000100;
    localparam logic [5:0] S_SHIFT   = 6'b001000;
    localparam logic [5:0] S_ACK     = 6'b010000;
    localparam logic [5:0] S_WAIT    = 6'b100000;

    localparam int PMAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int WW   = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, clk_prev;
    logic          data_s1, data_s2;
    logic [5:0]    state;
    logic [PW-1:0] phase_cnt;
    logic [WW-1:0] wdog;
    logic [9:0]    shreg;
    logic [3:0]    bitcnt;
    logic          data_oe_r;
    logic [1:0]    code_r;
    logic          fall, accept, watched, timeout_hit, line_idle, finish, nack_err;

    // Synchronisers preset high so reset never manufactures a falling edge.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fall        = clk_prev & ~clk_s2;
    assign accept      = host.tx_valid && (state == S_IDLE);
    assign watched     = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT);
    assign timeout_hit = watched && (wdog == WW'(TIMEOUT_CYCLES));
    assign line_idle   = clk_s2 && data_s2;
    assign finish      = (state == S_WAIT) && line_idle && !timeout_hit;

`ifdef PS2_TX_ACK_CHECK_EN
    logic ack_bad;
    assign nack_err = finish && ack_bad;

    always_ff @(posedge board_clk) begin
        if (reset)
            ack_bad <= 1'b0;
        else if ((state == S_ACK) && fall)
            ack_bad <= data_s2;
    end
`else
    assign nack_err = 1'b0;
`endif

    assign host.tx_ready = (state == S_IDLE);
    assign host.busy     = (state != S_IDLE);
    assign host.tx_done  = finish && !nack_err;
    assign host.tx_err   = timeout_hit || nack_err;
    // Error code is shown live in the pulse cycle and held from the register afterwards.
    assign host.err_code = timeout_hit ? 2'd1 : (nack_err ? 2'd2 : code_r);

    assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_START);
    assign ps2_data_oe = data_oe_r && !timeout_hit;

    always_ff @(posedge board_clk) begin
        if (reset) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            wdog      <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            data_oe_r <= 1'b0;
            code_r    <= 2'd0;
        end else begin
            if (!watched || fall)
                wdog <= '0;
            else
                wdog <= wdog + 1'b1;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_INHIBIT;
                        shreg     <= {1'b1, ~^host.tx_data, host.tx_data};
                        phase_cnt <= '0;
                        code_r    <= 2'd0;
                    end
                end
                S_INHIBIT: begin
                    if (phase_cnt == PW'(INHIBIT_CYCLES - 1)) begin
                        state     <= S_START;
                        phase_cnt <= '0;
                        data_oe_r <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_START: begin
                    if (phase_cnt == PW'(START_CYCLES - 1)) begin
                        state  <= S_SHIFT;
                        bitcnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Falls 1..10 present D0..D7, parity, stop from the LSB of the frame.
                    if (fall) begin
                        data_oe_r <= ~shreg[0];
                        shreg     <= shreg >> 1;
                        bitcnt    <= bitcnt + 1'b1;
                        if (bitcnt == 4'd9)
                            state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (fall)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (line_idle) begin
                        state  <= S_IDLE;
                        code_r <= nack_err ? 2'd2 : 2'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (timeout_hit) begin
                state     <= S_IDLE;
                data_oe_r <= 1'b0;
                code_r    <= 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the pins.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int STR  = 4;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic board_clk = 1'b0;
  logic reset     = 1'b1;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  ps2_host_tx_if host ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_CYCLES  (STR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .host       (host),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 board_clk = ~board_clk;

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  int last_acc_cyc = -100;

  always @(negedge board_clk) begin
    cyc++;
    if (host.tx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (host.tx_err) err_cnt++;
    if (host.tx_ready && host.tx_valid) last_acc_cyc = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic request(input logic [7:0] d, output bit ok);
    host.tx_data  = d;
    host.tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge board_clk);
      if (host.busy) begin
        ok = 1'b1;
        break;
      end
    end
    host.tx_valid = 1'b0;
  endtask

  // Device side: wait for the start bit, then clock 11 pulses, acking on the 11th if asked.
  task automatic device_frame(input bit ack, input int stop_after,
                              output logic [9:0] bits, output bit ok);
    ok = 1'b0;
    bits = '0;
    for (int i = 0; i < INH + STR + 60; i++) begin
      @(negedge board_clk);
      if (!ps2_clk_oe && !ps2_data_in) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    repeat (HALF) @(negedge board_clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (2) @(negedge board_clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge board_clk);
      if (k <= 10) bits[k-1] = ~ps2_data_oe;
      if (k == stop_after) return;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (HALF) @(negedge board_clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (host.tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge board_clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [9:0] frame;
    int         ndone;
    int         nerr;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [9:0] bits;
    int d0, e0, n;

    vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0, 2'd0};
    vecs[1] = '{8'h01, 1'b1, 10'h201, 1, 0, 2'd0};
    vecs[2] = '{8'h00, 1'b1, 10'h300, 1, 0, 2'd0};
    vecs[3] = '{8'hFF, 1'b1, 10'h3FF, 1, 0, 2'd0};
    vecs[4] = '{8'h02, 1'b1, 10'h202, 1, 0, 2'd0};
`ifdef PS2_TX_ACK_CHECK_EN
    vecs[5] = '{8'hED, 1'b0, 10'h3ED, 0, 1, 2'd2};
`else
    vecs[5] = '{8'hED, 1'b0, 10'h3ED, 1, 0, 2'd0};
`endif

    host.tx_valid = 1'b0;
    host.tx_data  = '0;
    repeat (3) @(negedge board_clk);
    check("rst_ready", host.tx_ready, 1);
    check("rst_busy", host.busy, 0);
    check("rst_done", host.tx_done, 0);
    check("rst_err", host.tx_err, 0);
    check("rst_code", host.err_code, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    reset = 1'b0;
    repeat (2) @(negedge board_clk);

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      request(vecs[v].data, ok);
      check($sformatf("v%0d_accept", v), ok, 1);
      device_frame(vecs[v].ack, 0, bits, ok);
      check($sformatf("v%0d_start_seen", v), ok, 1);
      check($sformatf("v%0d_frame", v), bits, vecs[v].frame);
      wait_idle(ok);
      check($sformatf("v%0d_idle", v), ok, 1);
      check($sformatf("v%0d_done_pulses", v), done_cnt - d0, vecs[v].ndone);
      check($sformatf("v%0d_err_pulses", v), err_cnt - e0, vecs[v].nerr);
      check($sformatf("v%0d_err_code", v), host.err_code, vecs[v].code);
      repeat (5) @(negedge board_clk);
    end

    // Inhibit/start phase lengths, then a silent device trips the watchdog.
    request(8'h55, ok);
    check("to_accept", ok, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
      n++;
      @(negedge board_clk);
    end
    check("inhibit_cycles", n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < STR + 10) begin
      n++;
      @(negedge board_clk);
    end
    check("start_cycles", n, STR);
    n = 1;
    while (!host.tx_err && n < TMO + 10) begin
      @(negedge board_clk);
      n++;
    end
    check("timeout_cycles", n, TMO + 1);
    check("timeout_code", host.err_code, 1);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    check("timeout_data_oe", ps2_data_oe, 0);
    @(negedge board_clk);
    check("timeout_ready", host.tx_ready, 1);
    check("timeout_code_held", host.err_code, 1);
    repeat (5) @(negedge board_clk);

    // Reset while the device is mid-frame.
    request(8'hA5, ok);
    device_frame(1'b1, 4, bits, ok);
    check("mid_start_seen", ok, 1);
    reset = 1'b1;
    @(negedge board_clk);
    check("mid_rst_clk_oe", ps2_clk_oe, 0);
    check("mid_rst_data_oe", ps2_data_oe, 0);
    check("mid_rst_ready", host.tx_ready, 1);
    check("mid_rst_busy", host.busy, 0);
    reset = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) @(negedge board_clk);
    d0 = done_cnt;
    request(8'hF4, ok);
    device_frame(1'b1, 0, bits, ok);
    check("f4_frame", bits, 10'h2F4);
    wait_idle(ok);
    check("f4_done_pulses", done_cnt - d0, 1);
    check("f4_code", host.err_code, 0);
    repeat (5) @(negedge board_clk);

    // tx_valid held across two frames with the data changed while busy.
    d0 = done_cnt;
    host.tx_data  = 8'hED;
    host.tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge board_clk);
      if (host.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b_first_accept", ok, 1);
    host.tx_data = 8'h02;
    device_frame(1'b1, 0, bits, ok);
    check("b2b_frame1", bits, 10'h3ED);
    check("b2b_accept_after_done", last_acc_cyc - last_done_cyc, 1);
    check("b2b_busy_again", host.busy, 1);
    host.tx_valid = 1'b0;
    device_frame(1'b1, 0, bits, ok);
    check("b2b_frame2", bits, 10'h202);
    wait_idle(ok);
    check("b2b_done_pulses", done_cnt - d0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter for the keyboard port. Serialises one command byte per request toward the keyboard, e.g. 0xFF reset, 0xED set-LEDs plus its argument, or 0xF4 enable. It drives PS2_CLK/PS2_DAT as open-drain pull-downs and tracks the device-generated clock. It sits beside the existing keyboard receiver on the same pins, and `busy` tells that receiver to discard any partial frame.

## Interface
Parameters:
- INHIBIT_CYCLES, 6000, board_clk cycles clock is held low before the start bit (120 µs at 50 MHz).
- START_CYCLES, 16, cycles data and clock are both held low before clock release.
- TIMEOUT_CYCLES, 750000, maximum cycles between consecutive device clock falling edges (15 ms).

Ports:
- board_clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- tx_data  in  8  command byte; sampled on accept.
- tx_valid  in  1  request; held until accepted.
- tx_ready  out  1  high only in IDLE; the transfer is accepted when tx_valid && tx_ready.
- tx_done  out  1  one-cycle pulse: frame sent and acknowledged.
- tx_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  0 = none, 1 = timeout, 2 = no ack; valid with tx_err, then held until the next accept.
- busy  out  1  high from accept until return to IDLE.
- ps2_clk_in, ps2_data_in  in  1  raw pin levels (asynchronous).
- ps2_clk_oe, ps2_data_oe  out  1  1 = pull the pin low; 0 = release (high-Z).

## Operation
- Pin inputs pass through 2-flop synchronisers.
- fall = previous & ~current on the synchronised clock.
- Shift frame captured at accept: {stop = 1, parity = ~^tx_data, tx_data[7:0]}, transmitted LSB first.
- State machine (one-hot):
  - IDLE: all oe = 0. On accept go to INHIBIT and latch tx_data.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYCLES cycles, then go to START.
  - START: clk_oe = 1 and data_oe = 1 (start bit) for START_CYCLES cycles. Then clk_oe = 0; go to SHIFT with bitcnt = 0 and the watchdog cleared.
  - SHIFT: on each fall, present the next bit: data_oe = ~bit. Falls 1–8 present D0–D7, fall 9 presents parity, fall 10 presents stop (data_oe = 0). After fall 10 go to ACK.
  - ACK: on fall 11, sample synchronised data. Low = ack. High = missing ack (see Configuration). Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronised clock and data are both high. Pulse tx_done (or tx_err) and return to IDLE.
- Watchdog:
  - Counts in SHIFT, ACK and WAIT_IDLE; cleared on every fall.
  - At TIMEOUT_CYCLES: both oe = 0, tx_err pulse, err_code = 1, return to IDLE.
- tx_valid while busy is ignored.
- An accept during an in-progress device transmission is legal: the inhibit overrides it.
- Reset, including mid-frame: next edge gives state IDLE, all oe = 0, tx_ready = 1, tx_done = 0, tx_err = 0, err_code = 0, busy = 0, watchdog = 0.

## Timing
- Accept at edge N:
  - busy = 1, tx_ready = 0, clk_oe = 1 from N+1.
  - data_oe = 1 from N+1+INHIBIT_CYCLES.
  - clk_oe = 0 from N+1+INHIBIT_CYCLES+START_CYCLES.
- Fall is detected 3 cycles after the pin edge. data_oe updates on the cycle after the fall is detected.
- tx_done/tx_err assert in the first cycle the idle condition is seen. tx_ready returns 1 on the following cycle.
- A back-to-back request can be accepted on the cycle after tx_done.

## Configuration
- PS2_TX_ACK_CHECK_EN defined: a high data level at fall 11 gives tx_err, err_code = 2, and no tx_done.
- Undefined: the ack level is ignored and tx_done always follows the idle wait. The no-ack code is never produced.

## Test plan
- Send 0xED, with a device model clocking at 12.5 kHz and acking. Required:
  - bits on data_oe inverted = 1,0,1,1,0,1,1,1, parity 1, stop released;
  - exactly one tx_done pulse, err_code = 0.
- Send 0x01: parity bit 0. Send 0x00 and 0xFF: parity bit 1.
- Device never clocks after START: tx_err at TIMEOUT_CYCLES+1 cycles after clock release, err_code = 1, both oe = 0.
- Device omits the ack (data high on fall 11):
  - with PS2_TX_ACK_CHECK_EN, tx_err and err_code = 2;
  - without it, tx_done.
- Assert reset during SHIFT at bit 4: next cycle both oe = 0, tx_ready = 1, busy = 0. A new 0xF4 request then completes normally.
- tx_valid held continuously with alternating tx_data 0xED/0x02: two consecutive frames, each with the correct data; a request presented while busy is not accepted until the cycle after tx_done.
